// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: the decoder presents source/destination
// information, the scoreboard answers with stall, forward selects and
// the mult/div busy flag.
interface hazard_scoreboard_if #(
  parameter int NSTAGE = 3,
  parameter int TW     = 2,
  parameter int AW     = 5
) ();
  localparam int FSW = $clog2(NSTAGE + 1);

  logic [AW-1:0]  d_rs;
  logic [AW-1:0]  d_rt;
  logic [TW-1:0]  d_tuse_rs;
  logic [TW-1:0]  d_tuse_rt;
  logic           d_we;
  logic [AW-1:0]  d_waddr;
  logic [TW-1:0]  d_tnew;
  logic           d_md_start;
  logic           d_md_kind;
  logic           d_md_use;
  logic           stall;
  logic [FSW-1:0] fwd_sel_rs;
  logic [FSW-1:0] fwd_sel_rt;
  logic           md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_waddr, d_tnew,
           d_md_start, d_md_kind, d_md_use,
    input  stall, fwd_sel_rs, fwd_sel_rt, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_waddr, d_tnew,
           d_md_start, d_md_kind, d_md_use,
    output stall, fwd_sel_rs, fwd_sel_rt, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall/forward scoreboard for the in-order pipeline. Keeps one
// {valid, waddr, tnew} record per post-decode stage, ages tnew every cycle
// and compares the youngest matching record against the D-stage tuse.
// A down-counter models the multi-cycle mult/div unit for HI/LO interlock.
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int TW       = 2,
  parameter int AW       = 5,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  hazard_scoreboard_if.slave hz
);
  localparam int FSW    = $clog2(NSTAGE + 1);
  localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW     = $clog2(MD_MAX + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  logic [NSTAGE-1:0] ent_valid;
  logic [AW-1:0]     ent_waddr [NSTAGE];
  logic [TW-1:0]     ent_tnew  [NSTAGE];

  logic [CW-1:0]     md_cnt;
  logic              md_busy;
  logic              stall;

  logic              hit_rs, haz_rs, hit_rt, haz_rt;
  logic [FSW-1:0]    sel_rs, sel_rt;
  logic              rs_used, rt_used;

  assign rs_used = (hz.d_tuse_rs != TUSE_NONE);
  assign rt_used = (hz.d_tuse_rt != TUSE_NONE);

  // Shift the stage records down the pipe; a stalled D inserts a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSTAGE; i++) begin
        ent_valid[i] <= 1'b0;
        ent_waddr[i] <= '0;
        ent_tnew[i]  <= '0;
      end
    end else begin
      ent_valid[0] <= !stall && hz.d_we && (hz.d_waddr != '0);
      ent_waddr[0] <= stall ? '0 : hz.d_waddr;
      ent_tnew[0]  <= stall ? '0 : hz.d_tnew;
      for (int i = 1; i < NSTAGE; i++) begin
        ent_valid[i] <= ent_valid[i-1];
        ent_waddr[i] <= ent_waddr[i-1];
        // tnew saturates so a forwardable result stays forwardable
        ent_tnew[i]  <= (ent_tnew[i-1] == '0) ? '0 : ent_tnew[i-1] - TW'(1);
      end
    end
  end

  // Youngest matching record for rs decides both stall and forward.
  always_comb begin
    hit_rs = 1'b0;
    haz_rs = 1'b0;
    sel_rs = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (!hit_rs && ent_valid[k] && (ent_waddr[k] == hz.d_rs) && (hz.d_rs != '0)) begin
        hit_rs = 1'b1;
        if (rs_used) begin
          haz_rs = (ent_tnew[k] > hz.d_tuse_rs);
          if (ent_tnew[k] == '0) sel_rs = FSW'(k + 1);
        end
      end
    end
  end

  // Same lookup for rt.
  always_comb begin
    hit_rt = 1'b0;
    haz_rt = 1'b0;
    sel_rt = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (!hit_rt && ent_valid[k] && (ent_waddr[k] == hz.d_rt) && (hz.d_rt != '0)) begin
        hit_rt = 1'b1;
        if (rt_used) begin
          haz_rt = (ent_tnew[k] > hz.d_tuse_rt);
          if (ent_tnew[k] == '0) sel_rt = FSW'(k + 1);
        end
      end
    end
  end

  // Mult/div occupancy: load on an accepted start, otherwise count down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (!stall && hz.d_md_start) begin
      md_cnt <= hz.d_md_kind ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy = (md_cnt != '0);
  assign stall   = haz_rs || haz_rt || (hz.d_md_use && md_busy);

  assign hz.stall      = stall;
  assign hz.fwd_sel_rs = sel_rs;
  assign hz.fwd_sel_rt = sel_rt;
  assign hz.md_busy    = md_busy;
endmodule
